// File: rtl/mem_access_unit.sv
// Load/store unit between the RV32I multicycle datapath and the word-wide BRAM.
// Byte/halfword stores are done as read-modify-write; loads are sign/zero extended.
module mem_access_unit #(
    parameter int WORDS      = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic [WORDS-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_wr_o,
    output logic                  mem_rd_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    typedef enum logic [1:0] {IDLE, RD, RMW, WR} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t      state;
    logic [2:0]  f3_p0;
    logic [1:0]  off_p0;
    logic [15:0] wdata_p0;
    logic        legal;
    logic        unused_addr_bits;

    // Upper address bits are deliberately dropped so accesses wrap over the memory.
    assign unused_addr_bits = ^addr_i[31:WORDS+2];

    function automatic logic is_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~we;
            F3_HU:   ok = ~we & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [2:0] f3,
                                                          input logic [1:0] off,
                                                          input logic [DATA_WIDTH-1:0] word);
        logic [DATA_WIDTH-1:0] byte_sh;
        logic [DATA_WIDTH-1:0] half_sh;
        logic [DATA_WIDTH-1:0] res;
        byte_sh = word >> {off, 3'b000};
        half_sh = word >> {off[1], 4'b0000};
        case (f3)
            F3_B:    res = {{(DATA_WIDTH-8){byte_sh[7]}}, byte_sh[7:0]};
            F3_BU:   res = {{(DATA_WIDTH-8){1'b0}}, byte_sh[7:0]};
            F3_H:    res = {{(DATA_WIDTH-16){half_sh[15]}}, half_sh[15:0]};
            F3_HU:   res = {{(DATA_WIDTH-16){1'b0}}, half_sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_store(input logic [2:0] f3,
                                                          input logic [1:0] off,
                                                          input logic [15:0] data,
                                                          input logic [DATA_WIDTH-1:0] word);
        logic [4:0]            sh;
        logic [DATA_WIDTH-1:0] mask;
        logic [DATA_WIDTH-1:0] ins;
        if (f3 == F3_B) begin
            sh   = {off, 3'b000};
            mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << sh;
            ins  = {{(DATA_WIDTH-8){1'b0}}, data[7:0]} << sh;
        end else begin
            sh   = {off[1], 4'b0000};
            mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << sh;
            ins  = {{(DATA_WIDTH-16){1'b0}}, data} << sh;
        end
        return (word & ~mask) | (ins & mask);
    endfunction

    assign legal = is_legal(we_i, funct3_i, addr_i[1:0]);

    // E0 capture of the request fields needed by later phases
    always_ff @(posedge clk_i) begin
        if (state == IDLE && req_i) begin
            f3_p0    <= funct3_i;
            off_p0   <= addr_i[1:0];
            wdata_p0 <= wdata_i[15:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            rdata_o    <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            busy_o     <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            mem_wr_o   <= 1'b1;
            mem_rd_o   <= 1'b1;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        if (!legal) begin
                            done_o  <= 1'b1;
                            err_o   <= 1'b1;
                            rdata_o <= '0;
                        end else begin
                            mem_addr_o <= addr_i[WORDS+1:2];
                            busy_o     <= 1'b1;
                            if (we_i && funct3_i == F3_W) begin
                                mem_wr_o   <= 1'b0;
                                mem_data_o <= wdata_i;
                                state      <= WR;
                            end else if (we_i) begin
                                mem_rd_o <= 1'b0;
                                state    <= RMW;
                            end else begin
                                mem_rd_o <= 1'b0;
                                state    <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    mem_rd_o <= 1'b1;
                    rdata_o  <= extend_load(f3_p0, off_p0, mem_data_i);
                    done_o   <= 1'b1;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
                // Read data is back: splice the new lane in and write it out next cycle
                RMW: begin
                    mem_rd_o   <= 1'b1;
                    mem_wr_o   <= 1'b0;
                    mem_data_o <= merge_store(f3_p0, off_p0, wdata_p0, mem_data_i);
                    state      <= WR;
                end
                WR: begin
                    mem_wr_o <= 1'b1;
                    done_o   <= 1'b1;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: negedge-sampled BRAM model, scoreboard queue of
// expected load results checked by a monitor on every done_o pulse.
module tb_mem_access_unit;
    localparam int WORDS = 10;

    logic              clk = 1'b0;
    logic              reset, req, we;
    logic [2:0]        f3;
    logic [31:0]       addr, wdata, rdata;
    logic              done, err, busy;
    logic [WORDS-1:0]  mem_addr;
    logic [31:0]       mem_wdata, mem_rdata, mem_q;
    logic              mem_wr, mem_rd;
    logic [31:0]       mem [0:(1<<WORDS)-1];

    int passed = 0;
    int total  = 0;
    int rd_low = 0;
    int wr_low = 0;
    int both_low = 0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mem_access_unit #(.WORDS(WORDS), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .we_i(we), .funct3_i(f3),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .done_o(done),
        .err_o(err), .busy_o(busy), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
        .mem_wr_o(mem_wr), .mem_rd_o(mem_rd), .mem_data_i(mem_rdata)
    );

    // BRAM model: samples enables on the falling edge
    always @(negedge clk) begin
        if (!mem_rd) mem_q <= mem[mem_addr];
        if (!mem_wr) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem_q;

    always @(negedge clk) begin
        if (!mem_rd) rd_low++;
        if (!mem_wr) wr_low++;
        if (!mem_rd && !mem_wr) both_low++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {31'b0, done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_rdata"}, rdata, mon_e.rdata);
                check({mon_e.name, "_err"}, {31'b0, err}, {31'b0, mon_e.err});
            end
        end
    end

    // Called at a negedge; returns at the negedge where done_o is seen
    task automatic run(input string name, input logic w, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat, input int exp_rdc, input int exp_wrc);
        int   rd0, wr0, n;
        logic seen, busy1;
        exp_t e;
        e.name  = name;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        rd0 = rd_low;
        wr0 = wr_low;
        req = 1'b1; we = w; f3 = fn; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        seen = 1'b0; busy1 = 1'b0; n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) busy1 = busy;
            if (done) seen = 1'b1;
        end
        check({name, "_timeout"}, {31'b0, seen}, 32'd1);
        check({name, "_latency"}, n, exp_lat);
        check({name, "_busy"}, {31'b0, busy1}, {31'b0, exp_lat > 1});
        check({name, "_rd_cycles"}, rd_low - rd0, exp_rdc);
        check({name, "_wr_cycles"}, wr_low - wr0, exp_wrc);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rdata"},    rdata, 32'h0);
        check({tag, "_done"},     {31'b0, done}, 32'd0);
        check({tag, "_err"},      {31'b0, err}, 32'd0);
        check({tag, "_busy"},     {31'b0, busy}, 32'd0);
        check({tag, "_mem_addr"}, {22'b0, mem_addr}, 32'd0);
        check({tag, "_mem_data"}, mem_wdata, 32'h0);
        check({tag, "_mem_wr"},   {31'b0, mem_wr}, 32'd1);
        check({tag, "_mem_rd"},   {31'b0, mem_rd}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        reset = 1'b1; req = 1'b0; we = 1'b0; f3 = 3'b0; addr = '0; wdata = '0;
        for (int i = 0; i < (1 << WORDS); i++) mem[i] = 32'h0;
        mem[5]  = 32'h1111000B;
        mem[6]  = 32'h0000000C;
        mem[7]  = 32'h55667788;
        mem[18] = 32'hD0B0A090;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);

        // Loads
        run("lw_14",   1'b0, 3'b010, 32'h14, 32'h0, 32'h1111000B, 1'b0, 2, 1, 0);
        run("lb_48",   1'b0, 3'b000, 32'h48, 32'h0, 32'hFFFFFF90, 1'b0, 2, 1, 0);
        run("lb_49",   1'b0, 3'b000, 32'h49, 32'h0, 32'hFFFFFFA0, 1'b0, 2, 1, 0);
        run("lbu_4b",  1'b0, 3'b100, 32'h4B, 32'h0, 32'h000000D0, 1'b0, 2, 1, 0);
        run("lh_4a",   1'b0, 3'b001, 32'h4A, 32'h0, 32'hFFFFD0B0, 1'b0, 2, 1, 0);
        run("lhu_48",  1'b0, 3'b101, 32'h48, 32'h0, 32'h0000A090, 1'b0, 2, 1, 0);
        run("lhu_4a",  1'b0, 3'b101, 32'h4A, 32'h0, 32'h0000D0B0, 1'b0, 2, 1, 0);

        // Stores: rdata must keep the last load result
        run("sb_19",   1'b1, 3'b000, 32'h19, 32'h123456AB, 32'h0000D0B0, 1'b0, 3, 1, 1);
        check("sb_mem6", mem[6], 32'h0000AB0C);
        run("sh_1a",   1'b1, 3'b001, 32'h1A, 32'hFFFF1234, 32'h0000D0B0, 1'b0, 3, 1, 1);
        check("sh_mem6", mem[6], 32'h1234AB0C);
        run("sw_20",   1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0000D0B0, 1'b0, 2, 0, 1);
        check("sw_mem8", mem[8], 32'hCAFEF00D);

        // Misaligned and illegal requests
        run("lw_mis_22",  1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        run("sh_mis_23",  1'b1, 3'b001, 32'h23, 32'h5555, 32'h0, 1'b1, 1, 0, 0);
        run("ld_f3_011",  1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        run("st_f3_100",  1'b1, 3'b100, 32'h10, 32'h77, 32'h0, 1'b1, 1, 0, 0);
        check("err_mem8", mem[8], 32'hCAFEF00D);
        check("err_mem6", mem[6], 32'h1234AB0C);
        check("err_mem4", mem[4], 32'h0);

        // High address bits are ignored
        run("lw_wrap", 1'b0, 3'b010, 32'h10000014, 32'h0, 32'h1111000B, 1'b0, 2, 1, 0);

        // Reset at E1 of a byte store
        wr0 = wr_low;
        req = 1'b1; we = 1'b1; f3 = 3'b000; addr = 32'h1C; wdata = 32'hEE;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("rst_rmw_rd_phase", {31'b0, mem_rd}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("rst_mid");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem7", mem[7], 32'h55667788);
        check("rst_wr_cycles", wr_low - wr0, 32'd0);
        run("lw_after_rst", 1'b0, 3'b010, 32'h1C, 32'h0, 32'h55667788, 1'b0, 2, 1, 0);

        repeat (2) @(negedge clk);
        check("enables_both_low", both_low, 32'd0);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
